// File: rtl/bus_arbiter.sv
// Two-master / one-slave femto bus arbiter: registered grant held for a whole transaction,
// fault termination on no-slave decode or timeout. Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int BUS_WIDTH      = 32,
    parameter int BUS_ACC_CNT    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PRIO_M1        = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          m0_req,
    input  logic [XLEN-1:0]                               m0_addr,
    input  logic                                          m0_w_rb,
    input  logic [((BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1)-1:0] m0_acc,
    input  logic [BUS_WIDTH-1:0]                          m0_wdata,
    output logic                                          m0_resp,
    output logic [BUS_WIDTH-1:0]                          m0_rdata,
    output logic                                          m0_fault,
    input  logic                                          m1_req,
    input  logic [XLEN-1:0]                               m1_addr,
    input  logic                                          m1_w_rb,
    input  logic [((BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1)-1:0] m1_acc,
    input  logic [BUS_WIDTH-1:0]                          m1_wdata,
    output logic                                          m1_resp,
    output logic [BUS_WIDTH-1:0]                          m1_rdata,
    output logic                                          m1_fault,
    output logic                                          s_req,
    output logic [XLEN-1:0]                               s_addr,
    output logic                                          s_w_rb,
    output logic [((BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1)-1:0] s_acc,
    output logic [BUS_WIDTH-1:0]                          s_wdata,
    input  logic                                          s_resp,
    input  logic [BUS_WIDTH-1:0]                          s_rdata,
    input  logic                                          s_fault,
    input  logic                                          s_bus_fault,
    output logic                                          timeout
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic               last_q, last_d;
`endif

    logic               busy, sel_req, hit_tmo, done, winner, fault_v;
    logic [BUS_WIDTH-1:0] rdata_v;

    assign busy    = (state_q == BUSY);
    assign sel_req = grant_q ? m1_req : m0_req;
    assign hit_tmo = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
    assign done    = busy & (s_resp | s_bus_fault | hit_tmo);

    // Slave response wins over a decode fault, which wins over the timeout abort.
    assign rdata_v = s_resp ? s_rdata : '0;
    assign fault_v = s_resp ? s_fault : 1'b1;

    assign s_req   = busy & sel_req;
    assign s_addr  = rst ? '0 : (grant_q ? m1_addr  : m0_addr);
    assign s_w_rb  = rst ? '0 : (grant_q ? m1_w_rb  : m0_w_rb);
    assign s_acc   = rst ? '0 : (grant_q ? m1_acc   : m0_acc);
    assign s_wdata = rst ? '0 : (grant_q ? m1_wdata : m0_wdata);

    assign m0_resp  = done & ~grant_q;
    assign m1_resp  = done &  grant_q;
    assign m0_rdata = m0_resp ? rdata_v : '0;
    assign m1_rdata = m1_resp ? rdata_v : '0;
    assign m0_fault = m0_resp & fault_v;
    assign m1_fault = m1_resp & fault_v;
    assign timeout  = timeout_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign winner = (m0_req & m1_req) ? ~last_q : m1_req;
`else
    assign winner = (m0_req & m1_req) ? (PRIO_M1 != 0) : m1_req;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    state_d   = BUSY;
                    grant_d   = winner;
                    tmo_cnt_d = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_d    = winner;
`endif
                end
            end
            BUSY: begin
                if (done) begin
                    state_d   = IDLE;
                    tmo_cnt_d = '0;
                    if (!s_resp && !s_bus_fault) timeout_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: the bench plays both masters and the slave,
// expected completions go into a scoreboard queue checked by a negedge monitor.
module tb_bus_arbiter;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_w_rb = 1'b0, m1_req = 1'b0, m1_w_rb = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [1:0]  m0_acc = '0, m1_acc = '0;
    logic        m0_resp, m0_fault, m1_resp, m1_fault;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_w_rb;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_acc;
    logic        s_resp = 1'b0, s_fault = 1'b0, s_bus_fault = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        timeout;

    typedef struct packed { logic mst; logic [31:0] rdata; logic fault; } exp_t;
    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Slave model: mode 0 responds slv_delay cycles after s_req rises, 1 = unmapped, 2 = hangs.
    int          slv_mode = 0;
    int          slv_delay = 0;
    logic [31:0] slv_rdata = '0;
    int          scnt = 0;

    bus_arbiter #(.XLEN(32), .BUS_WIDTH(32), .BUS_ACC_CNT(4), .TIMEOUT_CYCLES(TMO), .PRIO_M1(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata),
        .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata),
        .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
        .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
        .s_resp(s_resp), .s_rdata(s_rdata), .s_fault(s_fault), .s_bus_fault(s_bus_fault),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (s_req) scnt = scnt + 1; else scnt = 0;
        s_resp      = (slv_mode == 0) && s_req && (scnt == slv_delay + 1);
        s_rdata     = s_resp ? slv_rdata : 32'h1234_5678;
        s_fault     = s_resp ? 1'b0 : 1'b1;
        s_bus_fault = (slv_mode == 1) && s_req;
    end

    function automatic exp_t mk_exp(input logic mst, input logic [31:0] rd, input logic f);
        exp_t e;
        e.mst = mst; e.rdata = rd; e.fault = f;
        return e;
    endfunction

    task automatic sb_monitor();
        exp_t        e;
        logic [31:0] rd;
        logic        fl;
        forever begin
            @(negedge clk);
            n_cmp++;
            if ((!m0_resp && (m0_rdata !== '0 || m0_fault !== 1'b0)) ||
                (!m1_resp && (m1_rdata !== '0 || m1_fault !== 1'b0)) || (m0_resp && m1_resp)) begin
                n_err++;
                $display("FAIL idle_outputs_zero: got m0 %b/%h/%b m1 %b/%h/%b, required no double resp and zero rdata/fault without resp",
                         m0_resp, m0_rdata, m0_fault, m1_resp, m1_rdata, m1_fault);
            end
            if (m0_resp || m1_resp) begin
                rd = m1_resp ? m1_rdata : m0_rdata;
                fl = m1_resp ? m1_fault : m0_fault;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_resp: got resp from m%0d, required none", m1_resp);
                end else begin
                    e = sb_q.pop_front();
                    if ({m1_resp, rd, fl} !== {e.mst, e.rdata, e.fault}) begin
                        n_err++;
                        $display("FAIL sb_completion: got m%0d rdata %h fault %b, required m%0d rdata %h fault %b",
                                 m1_resp, rd, fl, e.mst, e.rdata, e.fault);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        m0_addr = 32'h0000_1111; m0_wdata = 32'hAAAA_5555; m0_acc = 2'd3; m0_w_rb = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_req, s_addr, s_wdata, s_acc, s_w_rb, m0_resp, m1_resp, timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got s_req %b s_addr %h s_wdata %h timeout %b, required all 0",
                     s_req, s_addr, s_wdata, timeout);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_req, s_addr, s_wdata} !== {1'b0, 32'h0000_1111, 32'hAAAA_5555}) begin
            n_err++;
            $display("FAIL idle_mux_m0: got s_req %b s_addr %h s_wdata %h, required 0 00001111 aaaa5555",
                     s_req, s_addr, s_wdata);
        end
        #2;
    endtask

    task automatic test_round_robin();
        logic exp_m [4];
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_m = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_m = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        slv_mode = 0; slv_delay = 0; slv_rdata = 32'hCAFE_0001;
        m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000; m0_w_rb = 1'b0; m1_w_rb = 1'b0;
        for (int i = 0; i < 4; i++) sb_q.push_back(mk_exp(exp_m[i], 32'hCAFE_0001, 1'b0));
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
            #1;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL tie_sequence_done: got %0d completions pending, required 0", sb_q.size());
            sb_q.delete();
        end
        #1 m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_single_read();
        int sreq_n = 0;
        int resp_k = -1;
        slv_mode = 0; slv_delay = 2; slv_rdata = 32'hDEAD_BEEF;
        m0_addr = 32'h1000_0004; m0_w_rb = 1'b0; m0_acc = 2'd2;
        sb_q.push_back(mk_exp(1'b0, 32'hDEAD_BEEF, 1'b0));
        m0_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (s_req) sreq_n++;
            if (m0_resp) begin
                resp_k = k;
                n_cmp++;
                if (m0_rdata !== 32'hDEAD_BEEF || m0_fault !== 1'b0) begin
                    n_err++;
                    $display("FAIL read_data: got %h fault %b, required deadbeef fault 0", m0_rdata, m0_fault);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if ({s_req, s_addr, s_w_rb, s_acc} !== {1'b1, 32'h1000_0004, 1'b0, 2'd2}) begin
                    n_err++;
                    $display("FAIL read_fields: got s_req %b s_addr %h w_rb %b acc %0d, required 1 10000004 0 2",
                             s_req, s_addr, s_w_rb, s_acc);
                end
            end
            #2;
            if (resp_k == k) m0_req = 1'b0;
        end
        n_cmp++;
        if (sreq_n != 3 || resp_k != 3) begin
            n_err++;
            $display("FAIL read_latency: got s_req cycles %0d resp at %0d, required 3 and 3", sreq_n, resp_k);
        end
    endtask

    task automatic test_back_to_back();
        int r1_k = -1;
        int r0_k = -1;
        // Fixed priority favours m1; round-robin also picks m1 because m0 held the previous grant.
        slv_mode = 0; slv_delay = 0; slv_rdata = 32'h0B0B_0B0B;
        sb_q.push_back(mk_exp(1'b1, 32'h0B0B_0B0B, 1'b0));
        sb_q.push_back(mk_exp(1'b0, 32'h0B0B_0B0B, 1'b0));
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (m1_resp) r1_k = k;
            if (m0_resp) r0_k = k;
            #2;
            if (r1_k == k) m1_req = 1'b0;
            if (r0_k == k) m0_req = 1'b0;
        end
        n_cmp++;
        if (r1_k != 1 || r0_k != 3) begin
            n_err++;
            $display("FAIL tie_bubble: got m1 resp at %0d m0 resp at %0d, required 1 and 3", r1_k, r0_k);
        end
    endtask

    task automatic test_bus_fault();
        slv_mode = 1;
        m1_addr = 32'h5000_0000; m1_w_rb = 1'b1; m1_wdata = 32'h7777_7777;
        sb_q.push_back(mk_exp(1'b1, 32'h0, 1'b1));
        m1_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m1_resp, m1_fault, m1_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL bus_fault_resp: got resp %b fault %b rdata %h, required 1 1 0", m1_resp, m1_fault, m1_rdata);
        end
        #2 m1_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (timeout !== 1'b0 || s_req !== 1'b0) begin
            n_err++;
            $display("FAIL bus_fault_no_timeout: got timeout %b s_req %b, required 0 0", timeout, s_req);
        end
        #2;
    endtask

    task automatic test_timeout();
        int resp_k = -1;
        slv_mode = 2;
        m0_addr = 32'h3000_0000; m0_w_rb = 1'b0;
        sb_q.push_back(mk_exp(1'b0, 32'h0, 1'b1));
        m0_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m0_resp) begin
                resp_k = k;
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_flag_early: got %b, required 0", timeout);
                end
            end
            if (resp_k > 0 && k == resp_k + 1) begin
                n_cmp++;
                if (timeout !== 1'b1) begin
                    n_err++;
                    $display("FAIL timeout_flag_set: got %b, required 1", timeout);
                end
            end
            #2;
            if (resp_k == k) m0_req = 1'b0;
        end
        n_cmp++;
        if (resp_k != TMO || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_latency: got resp at %0d flag %b, required %0d and 1", resp_k, timeout, TMO);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic first;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        slv_mode = 2;
        m0_addr = 32'h4000_0000; m0_wdata = 32'h0F0F_0F0F;
        m0_req = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (s_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_busy: got s_req %b, required 1", s_req);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_req, s_addr, s_wdata, m0_resp, m1_resp, timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got s_req %b s_addr %h resp %b%b timeout %b, required all 0",
                     s_req, s_addr, m0_resp, m1_resp, timeout);
        end
        slv_mode = 0; slv_delay = 0; slv_rdata = 32'h5EED_0000;
        m1_req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        sb_q.push_back(mk_exp(first, 32'h5EED_0000, 1'b0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
            #1;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL post_reset_grant: got %0d completions pending, required 0", sb_q.size());
            sb_q.delete();
        end
        #1 m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (s_req !== 1'b0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL final_quiet: got s_req %b pending %0d, required 0 0", s_req, sb_q.size());
        end
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_round_robin();
        test_single_read();
        test_back_to_back();
        test_bus_fault();
        test_timeout();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
